reset_request_gen: RTL and testbench

- Generates the raw active-low system reset request that feeds the clock/reset block's external reset input (`rst_n_in`).
- Runs on the 27 MHz board clock, so it operates before and independent of PLL lock.
- Merges three reset sources into one minimum-width reset pulse and records which source fired:
  - the debounced user push-button,
  - a software request pulse,
  - a kick-based watchdog.

---
 rtl/reset_request_gen.sv | 135 +++++++++++++
 tb/tb_reset_request_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_request_gen.sv
// Merges push-button, software and watchdog reset sources into one fixed-width
// active-low reset request on the free-running board clock, and records the cause.
module reset_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned PULSE_CYCLES    = 2700,
  parameter int unsigned WDT_CYCLES      = 27000000,
  parameter bit          WDT_EN          = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       btn_n,
  input  logic       sw_req,
  input  logic       wdt_kick,
  output logic       rst_req_n,
  output logic [1:0] cause,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PUL_W = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t           state;
  logic             btn_s1;
  logic             btn_s2;
  logic             btn_deb;
  logic             btn_deb_q;
  logic [DEB_W-1:0] deb_cnt;
  logic [PUL_W-1:0] pulse_cnt;
  logic [WDT_W-1:0] wdt_cnt;
  logic             press_evt;
  logic             wdt_timeout;
  logic [1:0]       evt_cause;
  logic             evt_any;

  assign state_dbg   = state;
  assign press_evt   = btn_deb_q & ~btn_deb;
  assign wdt_timeout = WDT_EN && (state == ST_IDLE) &&
                       (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) && !wdt_kick;

  // Simultaneous events resolve as button > watchdog > software.
  always_comb begin
    evt_cause = 2'b00;
    if (press_evt)        evt_cause = 2'b01;
    else if (wdt_timeout) evt_cause = 2'b11;
    else if (sw_req)      evt_cause = 2'b10;
  end

  assign evt_any = (evt_cause != 2'b00);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      btn_deb   <= 1'b1;
      btn_deb_q <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      btn_s1    <= btn_n;
      btn_s2    <= btn_s1;
      btn_deb_q <= btn_deb;
      if (btn_s2 != btn_deb) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_deb <= btn_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Clearing on any accepted event also covers the terminal count, so no wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wdt_cnt <= '0;
    end else if (!WDT_EN || state != ST_IDLE || wdt_kick || evt_any) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      rst_req_n <= 1'b1;
      busy      <= 1'b0;
      cause     <= 2'b00;
      pulse_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (evt_any) begin
            state     <= ST_ASSERT;
            cause     <= evt_cause;
            rst_req_n <= 1'b0;
            busy      <= 1'b1;
            pulse_cnt <= '0;
          end
        end
        ST_ASSERT: begin
          if (pulse_cnt == PUL_W'(PULSE_CYCLES - 1)) begin
            state     <= ST_HOLDOFF;
            rst_req_n <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt + PUL_W'(1);
          end
        end
        ST_HOLDOFF: begin
          // A held button keeps us here so one press yields exactly one pulse.
          if (btn_deb) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rst_req_n <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Bench for reset_request_gen: cycle-timestamp reference model with a per-cycle
// expected queue, plus directed checks at hand-computed cycles.
module tb_reset_request_gen;

  localparam int D = 8;
  localparam int P = 4;
  localparam int W = 20;
  localparam bit WDT_EN = 1'b1;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       btn_n    = 1'b1;
  logic       sw_req   = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       rst_req_n;
  logic [1:0] cause;
  logic       busy;
  logic [1:0] state_dbg;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .WDT_CYCLES     (W),
    .WDT_EN         (WDT_EN)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .btn_n    (btn_n),
    .sw_req   (sw_req),
    .wdt_kick (wdt_kick),
    .rst_req_n(rst_req_n),
    .cause    (cause),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk_in = ~clk_in;

  int         n_cmp  = 0;
  int         n_err  = 0;
  int         cyc    = 0;
  int         pulses = 0;
  logic       prev_rst = 1'b1;
  logic [3:0] exp_q[$];

  // model state: pulse is a timestamp window, watchdog count is cycles since wd_ref
  bit         m_active;
  int         m_start;
  logic [1:0] m_cause;
  bit         m_deb;
  bit         m_deb_prev;
  int         m_wd_ref;
  bit         m_hist[$];

  task automatic model_step();
    int         c;
    bit         press;
    bit         tmo;
    bit         flip;
    logic [1:0] ev;
    c = cyc;
    if (!rst_n_in) begin
      m_active   = 1'b0;
      m_start    = 0;
      m_cause    = 2'b00;
      m_deb      = 1'b1;
      m_deb_prev = 1'b1;
      m_wd_ref   = c + 1;
      m_hist     = {};
      for (int i = 0; i < D + 2; i++) m_hist.push_back(1'b1);
    end else begin
      press = m_deb_prev && !m_deb;
      tmo   = WDT_EN && !m_active && (c - m_wd_ref == W - 1) && !wdt_kick;
      ev    = press ? 2'd1 : tmo ? 2'd3 : sw_req ? 2'd2 : 2'd0;
      // debounced state flips after D consecutive synchronized samples disagree
      flip = 1'b1;
      for (int i = 1; i <= D; i++) if (m_hist[i] == m_deb) flip = 1'b0;
      if (!m_active) begin
        if (ev != 2'd0) begin
          m_active = 1'b1;
          m_start  = c + 1;
          m_cause  = ev;
        end else if (wdt_kick) begin
          m_wd_ref = c + 1;
        end
      end else if (c >= m_start + P && m_deb) begin
        m_active = 1'b0;
        m_wd_ref = c + 1;
      end
      m_deb_prev = m_deb;
      if (flip) m_deb = !m_deb;
      m_hist.push_back(btn_n);
      m_hist.delete(0);
    end
    exp_q.push_back({(m_active && (c + 1) < m_start + P) ? 1'b0 : 1'b1, m_active, m_cause});
    cyc = c + 1;
  endtask

  task automatic compare_step();
    logic [3:0] e;
    logic [3:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n_in) e = 4'b1000;
      a = {rst_req_n, busy, cause};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_%0d {rst_req_n,busy,cause}: got %b required %b", cyc, a, e);
      end
    end
    if (prev_rst === 1'b1 && rst_req_n === 1'b0) pulses++;
    prev_rst = rst_req_n;
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] a;
    a = {rst_req_n, busy, cause};
    n_cmp++;
    if (a !== exp) begin
      n_err++;
      $display("FAIL %s {rst_req_n,busy,cause}: got %b required %b", name, a, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    int p0;
    fork
      forever begin @(posedge clk_in); model_step(); end
      forever begin @(negedge clk_in); compare_step(); end
    join_none

    // power-on and idle with regular kicks
    tick(3);
    check("reset_state", 4'b1000);
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(9);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
    end
    check("idle_after_kicks", 4'b1000);
    check_int("no_pulse_while_idle", pulses, 0);

    // software request
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("sw_assert_first", 4'b0110);
    tick(3);
    check("sw_assert_last", 4'b0110);
    tick(1);
    check("sw_holdoff", 4'b1110);
    tick(1);
    check("sw_idle", 4'b1010);

    // button bounce then hold, watchdog kept quiet
    wdt_kick = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      btn_n = (i % 2 == 1);
      tick(3);
    end
    btn_n = 1'b0;
    tick(10);
    check("btn_before_pulse", 4'b1010);
    tick(1);
    check("btn_pulse_start", 4'b0101);
    tick(29);
    check("btn_held_holdoff", 4'b1101);
    btn_n = 1'b1;
    tick(10);
    check("btn_release_holdoff", 4'b1101);
    tick(1);
    check("btn_idle", 4'b1001);
    check_int("btn_one_pulse", pulses - p0, 1);

    // watchdog timeout, then kick at count 19, then watchdog beats software
    wdt_kick = 1'b0;
    tick(19);
    check("wdt_before_timeout", 4'b1001);
    tick(1);
    check("wdt_timeout", 4'b0111);
    tick(5);
    check("wdt_idle_again", 4'b1011);
    tick(19);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    check("kick_at_19", 4'b1011);
    tick(10);
    check("kick_no_timeout", 4'b1011);
    tick(9);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("wdt_beats_sw", 4'b0111);
    tick(5);
    check("wdt_sw_idle", 4'b1011);
    wdt_kick = 1'b1;

    // collision with press event, then a request dropped during ASSERT
    p0 = pulses;
    btn_n = 1'b0;
    tick(10);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("collision_btn_wins", 4'b0101);
    tick(1);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    tick(7);
    check("drop_holdoff", 4'b1101);
    btn_n = 1'b1;
    tick(11);
    check("collision_idle", 4'b1001);
    check_int("collision_one_pulse", pulses - p0, 1);

    // reset in the second ASSERT cycle
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    tick(1);
    rst_n_in = 1'b0;
    #1;
    check("reset_mid_pulse", 4'b1000);
    tick(3);
    rst_n_in = 1'b1;
    p0 = pulses;
    tick(12);
    check("after_reset_idle", 4'b1000);
    check_int("no_resumed_pulse", pulses - p0, 0);

    // final report
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
